pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the fetch, decode and execute stages.
- Drives PC/fetch-decode stall, decode-to-execute bubble and hold, and fetch-decode flush.
- Covers load-use hazards, taken-branch recovery, multi-cycle strided vector ops (strd_cyc) and convolution-engine waits (conv_en).
- Holds the FSM state and counters; the stall/flush outputs are combinational from that state and the current inputs.

Parameters:
CONV_TIMEOUT, 1024, max cycles in CONV_WAIT before conv_err is raised and the wait is abandoned
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dec_valid  in  1  decode stage holds a real instruction
dec_rA  in  5  decode source register A
dec_rB  in  5  decode source register B
dec_use_rA  in  1  decode instruction reads rA
dec_use_rB  in  1  decode instruction reads rB
dec_strd_cyc  in  3  execute cycles needed by the decode instruction (0 or 1 = single cycle)
dec_conv_en  in  1  decode instruction launches the convolution engine
ex_ldr  in  1  execute-stage instruction is a load
ex_rD  in  5  execute-stage destination register
b_taken  in  1  branch resolved taken in execute
conv_done  in  1  convolution engine completion pulse
stall_pc  out  1  hold PC
stall_fd  out  1  hold fetch-to-decode register
flush_fd  out  1  zero fetch-to-decode register
bubble_dx  out  1  load zeros into decode-to-execute register
hold_dx  out  1  decode-to-execute register keeps its value
ex_busy  out  1  FSM not in RUN
conv_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1
state  out  2  RUN=0, MULTI=1, CONV_WAIT=2

Behaviour:
- Reset (sampled on the clk edge):
  - state=RUN, cyc_cnt=0, to_cnt=0, conv_err=0, stall_cnt=0.
  - While reset is high, all stall/flush/bubble/hold outputs are 0.
  - Reset mid-MULTI or mid-CONV_WAIT abandons the operation with no residual stall.
- Issue condition: issue = dec_valid & ~stall_pc & ~b_taken, evaluated in RUN.
- RUN, evaluated in priority order:
  1. b_taken=1: flush_fd=1, bubble_dx=1, stall_pc=0. Load-use and issue are suppressed, even if a hazard is present in the same cycle. State stays RUN.
  2. Load-use hazard: asserted when ex_ldr=1 & ex_rD!=0 & ((dec_use_rA & dec_rA==ex_rD) | (dec_use_rB & dec_rB==ex_rD)).
     - Outputs: stall_pc=1, stall_fd=1, bubble_dx=1 for exactly one cycle. The next cycle execute holds the bubble, so the hazard clears by itself.
  3. issue & dec_conv_en=1 → CONV_WAIT next cycle, to_cnt=0. Takes priority over strd_cyc.
  4. issue & dec_strd_cyc>=2 → MULTI next cycle, cyc_cnt=dec_strd_cyc-1.
  5. Otherwise no stall; state stays RUN.
- MULTI:
  - Outputs: stall_pc=1, stall_fd=1, hold_dx=1.
  - cyc_cnt decrements each cycle; when cyc_cnt==1, next state is RUN.
  - A strided op of N cycles therefore produces exactly N-1 stall cycles.
  - b_taken is ignored here, since the op in execute is not a branch.
- CONV_WAIT:
  - Outputs: stall_pc=1, stall_fd=1, hold_dx=1.
  - conv_done=1 → RUN next cycle; the stall is still asserted in the conv_done cycle.
  - to_cnt increments each cycle. If to_cnt==CONV_TIMEOUT-1 without conv_done: conv_err←1 (sticky until reset), → RUN.
  - conv_done and timeout in the same cycle: conv_done wins, conv_err stays unchanged.
  - conv_done seen outside CONV_WAIT is ignored. b_taken is ignored here.
- bubble_dx and hold_dx are never both 1.
- ex_busy = (state!=RUN).
- stall_cnt increments on every cycle with stall_pc=1 and saturates at all-ones (no wrap).

Test Plan:
- Load-use: ex_ldr=1, ex_rD=5, dec_rA=5, dec_use_rA=1 → one cycle of stall_pc=stall_fd=bubble_dx=1, then 0. Repeat with ex_rD=0 → no stall.
- Branch over hazard: b_taken=1 with the same load-use condition → flush_fd=bubble_dx=1, stall_pc=0, stall_cnt unchanged.
- Strided op: issue with dec_strd_cyc=4 → state MULTI for 3 cycles, stall_pc=hold_dx=1, then RUN; stall_cnt +3. dec_strd_cyc=1 → no stall.
- Conv: issue dec_conv_en=1, conv_done pulsed 7 cycles later → CONV_WAIT for 7 cycles, RUN on the 8th, conv_err=0. b_taken asserted mid-wait is ignored.
- Timeout: CONV_TIMEOUT=8, never pulse conv_done → RUN after 8 cycles, conv_err=1 and held. Pulse conv_done on the 8th cycle instead → conv_err=0.
- Reset mid-MULTI (dec_strd_cyc=7, reset at cycle 2) → next cycle state=RUN, all outputs 0, stall_cnt=0. Force stall_cnt to all-ones, then stall → value stays at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Fetch/decode/execute sequencing controller: load-use stalls, branch flush,
// multi-cycle strided ops and convolution-engine waits with timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned CONV_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rA,
  input  logic [4:0]       dec_rB,
  input  logic             dec_use_rA,
  input  logic             dec_use_rB,
  input  logic [2:0]       dec_strd_cyc,
  input  logic             dec_conv_en,
  input  logic             ex_ldr,
  input  logic [4:0]       ex_rD,
  input  logic             b_taken,
  input  logic             conv_done,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             bubble_dx,
  output logic             hold_dx,
  output logic             ex_busy,
  output logic             conv_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] MULTI     = 2'd1;
  localparam logic [1:0] CONV_WAIT = 2'd2;

  localparam int unsigned    TO_W    = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CONV_TIMEOUT - 1);

  logic [2:0]      cyc_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            load_use;
  logic            issue;

  assign load_use = ex_ldr && (ex_rD != 5'd0) &&
                    ((dec_use_rA && (dec_rA == ex_rD)) ||
                     (dec_use_rB && (dec_rB == ex_rD)));

  assign issue   = dec_valid && !stall_pc && !b_taken;
  assign ex_busy = (state != RUN);

  // Branch flush outranks the load-use stall; the busy states ignore both.
  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    flush_fd  = 1'b0;
    bubble_dx = 1'b0;
    hold_dx   = 1'b0;
    if (!reset) begin
      if (state == RUN) begin
        if (b_taken) begin
          flush_fd  = 1'b1;
          bubble_dx = 1'b1;
        end else if (load_use) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end else begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        hold_dx  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cyc_cnt   <= '0;
      to_cnt    <= '0;
      conv_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (issue) begin
            if (dec_conv_en) begin
              state  <= CONV_WAIT;
              to_cnt <= '0;
            end else if (dec_strd_cyc >= 3'd2) begin
              state   <= MULTI;
              cyc_cnt <= dec_strd_cyc - 3'd1;
            end
          end
        end
        MULTI: begin
          cyc_cnt <= cyc_cnt - 3'd1;
          if (cyc_cnt == 3'd1)
            state <= RUN;
        end
        CONV_WAIT: begin
          if (conv_done) begin
            state <= RUN;
          end else if (to_cnt == TO_LAST) begin
            conv_err <= 1'b1;
            state    <= RUN;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// expectations from a cycle-count reference model, compared by a separate monitor.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO   = 8;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_valid = 1'b0;
  logic [4:0]    dec_rA = '0;
  logic [4:0]    dec_rB = '0;
  logic          dec_use_rA = 1'b0;
  logic          dec_use_rB = 1'b0;
  logic [2:0]    dec_strd_cyc = '0;
  logic          dec_conv_en = 1'b0;
  logic          ex_ldr = 1'b0;
  logic [4:0]    ex_rD = '0;
  logic          b_taken = 1'b0;
  logic          conv_done = 1'b0;
  logic          stall_pc, stall_fd, flush_fd, bubble_dx, hold_dx, ex_busy, conv_err;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    state;

  pipe_hazard_ctrl #(.CONV_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rA(dec_rA), .dec_rB(dec_rB),
    .dec_use_rA(dec_use_rA), .dec_use_rB(dec_use_rB), .dec_strd_cyc(dec_strd_cyc),
    .dec_conv_en(dec_conv_en), .ex_ldr(ex_ldr), .ex_rD(ex_rD), .b_taken(b_taken),
    .conv_done(conv_done), .stall_pc(stall_pc), .stall_fd(stall_fd), .flush_fd(flush_fd),
    .bubble_dx(bubble_dx), .hold_dx(hold_dx), .ex_busy(ex_busy), .conv_err(conv_err),
    .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Expected vector: {state, stall_pc, stall_fd, flush_fd, bubble_dx, hold_dx, ex_busy, conv_err, stall_cnt}
  logic [8+CW:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: remaining stall cycles of a strided op, elapsed wait of a conv op.
  int multi_left = 0;
  bit conv_active = 1'b0;
  int conv_elapsed = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0; dec_valid = 1'b0; dec_rA = '0; dec_rB = '0; dec_use_rA = 1'b0;
    dec_use_rB = 1'b0; dec_strd_cyc = '0; dec_conv_en = 1'b0; ex_ldr = 1'b0;
    ex_rD = '0; b_taken = 1'b0; conv_done = 1'b0;
  endtask

  task automatic end_cycle();
    bit busy, haz;
    bit e_spc, e_sfd, e_flush, e_bub, e_hold;
    logic [1:0] e_state;
    busy = (multi_left > 0) || conv_active;
    haz  = ex_ldr && (ex_rD != 0) &&
           ((dec_use_rA && dec_rA == ex_rD) || (dec_use_rB && dec_rB == ex_rD));
    e_state = (multi_left > 0) ? 2'd1 : (conv_active ? 2'd2 : 2'd0);
    {e_spc, e_sfd, e_flush, e_bub, e_hold} = '0;
    if (!reset) begin
      if (busy)         {e_spc, e_sfd, e_hold} = 3'b111;
      else if (b_taken) {e_flush, e_bub} = 2'b11;
      else if (haz)     {e_spc, e_sfd, e_bub} = 3'b111;
    end
    exp_q.push_back({e_state, e_spc, e_sfd, e_flush, e_bub, e_hold, busy, m_err, CW'(m_cnt)});
    if (reset) begin
      multi_left = 0; conv_active = 1'b0; conv_elapsed = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (e_spc && m_cnt < CMAX) m_cnt++;
      if (multi_left > 0) begin
        multi_left--;
      end else if (conv_active) begin
        if (conv_done) conv_active = 1'b0;
        else begin
          conv_elapsed++;
          if (conv_elapsed == TO) begin
            m_err = 1'b1;
            conv_active = 1'b0;
          end
        end
      end else if (dec_valid && !b_taken && !haz) begin
        if (dec_conv_en) begin
          conv_active = 1'b1;
          conv_elapsed = 0;
        end else if (dec_strd_cyc >= 2) begin
          multi_left = dec_strd_cyc - 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic do_reset();
    begin_cycle(); reset = 1'b1; end_cycle();
  endtask

  task automatic issue_conv();
    begin_cycle(); dec_valid = 1'b1; dec_conv_en = 1'b1; end_cycle();
  endtask

  task automatic issue_strd(input logic [2:0] n);
    begin_cycle(); dec_valid = 1'b1; dec_strd_cyc = n; end_cycle();
  endtask

  initial begin : monitor
    logic [8+CW:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, stall_pc, stall_fd, flush_fd, bubble_dx, hold_dx, ex_busy, conv_err, stall_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs@cyc%0d {state,spc,sfd,flush,bub,hold,busy,err,cnt}: actual=%b required=%b",
                   checks, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    do_reset();
    do_reset();
    idle(1);

    // Load-use on rA, then the bubble cycle, then ex_rD=0 (no hazard), then rB hazard
    begin_cycle(); dec_valid = 1; ex_ldr = 1; ex_rD = 5; dec_rA = 5; dec_use_rA = 1; end_cycle();
    begin_cycle(); dec_valid = 1; dec_rA = 5; dec_use_rA = 1; end_cycle();
    begin_cycle(); dec_valid = 1; ex_ldr = 1; ex_rD = 0; dec_rA = 0; dec_use_rA = 1; end_cycle();
    begin_cycle(); dec_valid = 1; ex_ldr = 1; ex_rD = 9; dec_rB = 9; dec_use_rB = 1; end_cycle();
    begin_cycle(); dec_valid = 1; ex_ldr = 1; ex_rD = 9; dec_rB = 9; dec_use_rB = 0; end_cycle();

    // Branch over a load-use hazard and over a strided issue
    begin_cycle(); dec_valid = 1; ex_ldr = 1; ex_rD = 5; dec_rA = 5; dec_use_rA = 1; b_taken = 1; end_cycle();
    begin_cycle(); dec_valid = 1; dec_strd_cyc = 4; b_taken = 1; end_cycle();
    idle(1);

    // Strided ops
    issue_strd(3'd4); idle(4);
    issue_strd(3'd1); idle(1);
    issue_strd(3'd2); idle(2);

    // Conv with done seven cycles after issue, branch mid-wait
    issue_conv();
    for (int i = 1; i <= 7; i++) begin
      begin_cycle();
      b_taken = (i == 3);
      conv_done = (i == 7);
      end_cycle();
    end
    idle(2);

    // Conv priority over strided, timeout, sticky error
    begin_cycle(); dec_valid = 1; dec_conv_en = 1; dec_strd_cyc = 5; end_cycle();
    idle(TO + 3);
    issue_strd(3'd3); idle(3);

    // Done coinciding with the last timeout cycle
    do_reset();
    issue_conv();
    idle(TO - 1);
    begin_cycle(); conv_done = 1; end_cycle();
    idle(2);
    begin_cycle(); conv_done = 1; end_cycle();

    // Reset mid-MULTI
    issue_strd(3'd7); idle(2);
    do_reset();
    idle(2);

    // Stall counter saturation
    for (int k = 0; k < 9; k++) begin
      issue_conv();
      idle(TO);
    end
    issue_strd(3'd5); idle(5);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      begin_cycle();
      reset        = ($urandom_range(0, 79) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rA       = 5'($urandom_range(0, 3));
      dec_rB       = 5'($urandom_range(0, 3));
      dec_use_rA   = 1'($urandom);
      dec_use_rB   = 1'($urandom);
      dec_strd_cyc = 3'($urandom);
      dec_conv_en  = ($urandom_range(0, 9) == 0);
      ex_ldr       = 1'($urandom);
      ex_rD        = 5'($urandom_range(0, 3));
      b_taken      = ($urandom_range(0, 7) == 0);
      conv_done    = ($urandom_range(0, 5) == 0);
      end_cycle();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
